// File: rtl/seg_disp_ctrl.sv
// Bus-mapped six-digit seven-segment controller: shadowed digit values committed on
// display ticks, software enable and optional blink (built only with SEG_CTRL_BLINK_EN).
module seg_disp_ctrl #(
    parameter int         TICK_DIV  = 50000,
    parameter logic [9:0] BLINK_RST = 10'd500
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        sel,
    input  logic        mem_valid,
    input  logic [1:0]  mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    output logic        disp_en,
    output logic [3:0]  seg_0_val,
    output logic [3:0]  seg_1_val,
    output logic [3:0]  seg_2_val,
    output logic [3:0]  seg_3_val,
    output logic [3:0]  seg_4_val,
    output logic [3:0]  seg_5_val
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [1:0] A_VALUE  = 2'd0;
    localparam logic [1:0] A_CTRL   = 2'd1;
    localparam logic [1:0] A_DIV    = 2'd2;
    localparam logic [1:0] A_STATUS = 2'd3;

    logic [CW-1:0] tick_cnt;
    logic          tick;
    logic          accept;
    logic          wr;
    logic          rd;
    logic          wr_value;
    logic          wr_ctrl;
    logic [23:0]   value_q;
    logic [23:0]   seg_q;
    logic          pending_q;
    logic          en_q;
    logic          blink_q;
    logic          phase_q;
    logic [9:0]    blink_div_q;
    logic [31:0]   rd_mux;
    logic          unused_bits;

    // The ready cycle itself never accepts, so a held mem_valid completes every 2 cycles.
    assign accept   = mem_valid && sel && !mem_ready;
    assign wr       = accept && (mem_wstrb != 4'b0000);
    assign rd       = accept && (mem_wstrb == 4'b0000);
    assign wr_value = wr && (mem_addr == A_VALUE);
    assign wr_ctrl  = wr && (mem_addr == A_CTRL);
    assign tick     = (tick_cnt == CW'(TICK_DIV - 1));

    assign unused_bits = &{1'b0, mem_wdata[31:24]};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            value_q <= '0;
        end else if (wr_value) begin
            for (int b = 0; b < 3; b++) begin
                if (mem_wstrb[b]) value_q[8*b +: 8] <= mem_wdata[8*b +: 8];
            end
        end
    end

    // Commit copies the pre-edge shadow; a write on the same edge keeps PENDING for the next tick.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending_q <= 1'b0;
            seg_q     <= '0;
        end else begin
            if (tick && pending_q) seg_q <= value_q;
            if (wr_value) begin
                pending_q <= 1'b1;
            end else if (tick) begin
                pending_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            en_q <= 1'b0;
        end else if (wr_ctrl && mem_wstrb[0]) begin
            en_q <= mem_wdata[0];
        end
    end

`ifdef SEG_CTRL_BLINK_EN
    logic       wr_div;
    logic       blink_clr;
    logic [9:0] blink_cnt;

    assign wr_div = wr && (mem_addr == A_DIV) && (mem_wstrb[1:0] != 2'b00);
    // Counter and phase sit at their idle state whenever blink is off or being reprogrammed.
    assign blink_clr = !blink_q || wr_div || (wr_ctrl && mem_wstrb[0] && !mem_wdata[1]);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            blink_q     <= 1'b0;
            blink_div_q <= BLINK_RST;
        end else begin
            if (wr_ctrl && mem_wstrb[0]) blink_q <= mem_wdata[1];
            if (wr && (mem_addr == A_DIV)) begin
                if (mem_wstrb[0]) blink_div_q[7:0] <= mem_wdata[7:0];
                if (mem_wstrb[1]) blink_div_q[9:8] <= mem_wdata[9:8];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            blink_cnt <= '0;
            phase_q   <= 1'b1;
        end else if (blink_clr) begin
            blink_cnt <= '0;
            phase_q   <= 1'b1;
        end else if (tick) begin
            if (blink_div_q == 10'd0) begin
                blink_cnt <= '0;
                phase_q   <= 1'b1;
            end else if (blink_cnt == blink_div_q - 10'd1) begin
                blink_cnt <= '0;
                phase_q   <= ~phase_q;
            end else begin
                blink_cnt <= blink_cnt + 10'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            disp_en <= 1'b0;
        end else begin
            disp_en <= en_q && (!blink_q || phase_q);
        end
    end
`else
    assign blink_q     = 1'b0;
    assign phase_q     = 1'b1;
    assign blink_div_q = 10'd0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            disp_en <= 1'b0;
        end else begin
            disp_en <= en_q;
        end
    end
`endif

    always_comb begin
        rd_mux = 32'h0;
        case (mem_addr)
            A_VALUE:  rd_mux = {8'h00, value_q};
            A_CTRL:   rd_mux = {30'h0, blink_q, en_q};
            A_DIV:    rd_mux = {22'h0, blink_div_q};
            A_STATUS: rd_mux = {30'h0, phase_q, pending_q};
            default:  rd_mux = 32'h0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_ready <= 1'b0;
            mem_rdata <= '0;
        end else begin
            mem_ready <= accept;
            mem_rdata <= rd ? rd_mux : 32'h0;
        end
    end

    assign seg_0_val = seg_q[3:0];
    assign seg_1_val = seg_q[7:4];
    assign seg_2_val = seg_q[11:8];
    assign seg_3_val = seg_q[15:12];
    assign seg_4_val = seg_q[19:16];
    assign seg_5_val = seg_q[23:20];

endmodule

// File: doc/seg_disp_ctrl.md
# seg_disp_ctrl

Memory-mapped controller that sits between the PicoRV32 native memory bus and the six-digit scanning seven-segment driver. It holds the six 4-bit digit values in a shadow register, commits them to the display outputs only on 1 ms tick boundaries so a write never appears half-applied, and gates the driver enable with a software-controlled enable and an optional blink generator. It answers single-cycle register reads and writes with a one-cycle-latency ready handshake.

## Interface
- `TICK_DIV`, default 50000: clock cycles per display tick (1 ms at 50 MHz); minimum 2.
- `BLINK_RST`, default 10'd500: reset value of BLINK_DIV, in ticks.

- `clk` input 1: clock, 50 MHz.
- `reset_n` input 1: asynchronous, active-low reset.
- `sel` input 1: address-decoder select for this block's 16-byte window.
- `mem_valid` input 1: bus request valid.
- `mem_addr` input 2: word offset, `mem_addr[3:2]`.
- `mem_wdata` input 32: write data.
- `mem_wstrb` input 4: byte write strobes; 0 means read.
- `mem_ready` output 1: one-cycle completion pulse.
- `mem_rdata` output 32: read data, valid only while `mem_ready` is high.
- `disp_en` output 1: enable to the scan driver.
- `seg_0_val` … `seg_5_val` output 4 each: committed digit values; digit 0 is right-most.

## Operation
- Register map, word offsets:
  - 0 VALUE[23:0]: shadow register; nibble k is digit k. Bits [31:24] read 0.
  - 1 CTRL: bit0 EN, bit1 BLINK. Other bits read 0.
  - 2 BLINK_DIV[9:0]: blink half-period in ticks.
  - 3 STATUS, read-only: bit0 PENDING, bit1 PHASE.
- Byte strobes are honoured per lane. Lanes with no backing bits are ignored. Writes to STATUS are ignored.
- A transaction is accepted when `mem_valid && sel && !mem_ready`.
- Tick counter: counts 0..TICK_DIV-1 and wraps. `tick` is high in the cycle where the count equals TICK_DIV-1.
- Commit:
  - Any VALUE write with a nonzero strobe sets PENDING.
  - In a `tick` cycle with PENDING set, the shadow value as it stood before that edge is copied to `seg_*_val`, and PENDING is cleared.
  - If a VALUE write lands on the same edge as a commit, PENDING stays set, and the new value commits on the next tick.
- Blink:
  - A tick-driven counter runs while BLINK=1. PHASE toggles when the counter reaches BLINK_DIV-1, and the counter then returns to 0.
  - BLINK_DIV=0 holds PHASE=1.
  - Clearing BLINK, or writing BLINK_DIV, forces PHASE=1 and counter=0.
- `disp_en` is a registered output: `disp_en = EN && (!BLINK || PHASE)`.

## Timing
- Reset values:
  - `mem_ready`=0, `mem_rdata`=0, `disp_en`=0, all `seg_*_val`=0.
  - VALUE=0, CTRL=0, BLINK_DIV=BLINK_RST, PENDING=0, PHASE=1.
  - Tick counter and blink counter = 0.
- Handshake:
  - A request accepted at edge N gives `mem_ready`=1 for exactly cycle N+1, with `mem_rdata` valid in that same cycle.
  - `mem_ready` and `mem_rdata` return to 0 at cycle N+2.
  - A `mem_valid` still high during the ready cycle is not re-accepted. Back-to-back transactions therefore complete every 2 cycles.
- Write effects are visible in the registers from cycle N+1. A read issued in that cycle sees the new value.
- `disp_en` follows a change in CTRL or PHASE by 1 cycle.
- Worst-case VALUE-to-display latency is TICK_DIV+1 cycles.
- Reset asserted mid-transaction drops `mem_ready` immediately. No partial write survives.
- `sel`=0 with `mem_valid`=1: no response, and no register is touched.

## Configuration
- `SEG_CTRL_BLINK_EN` defined:
  - Blink counter, BLINK_DIV and CTRL.BLINK are implemented as described above.
- `SEG_CTRL_BLINK_EN` undefined:
  - No blink logic is built.
  - BLINK_DIV reads 0 and writes to it are ignored.
  - CTRL bit1 reads 0.
  - PHASE reads 1.
  - `disp_en = EN`.

## Test plan
- Reset, then read all four words. Expect VALUE=0, CTRL=0, BLINK_DIV=500, STATUS=0x2, `disp_en`=0, `mem_ready` high for exactly one cycle per read.
- Write VALUE=0x123456 with strobe 0xF. Expect PENDING=1 and `seg_*_val` unchanged until the first tick. One cycle after the tick, `seg_5_val`..`seg_0_val` = 1,2,3,4,5,6 and PENDING=0.
- Write VALUE byte 1 only (strobe 0x2, data 0x0000AB00) over 0x123456. Expect readback 0x12AB56.
- Time a VALUE write to complete exactly on the tick edge. Expect the old shadow to commit, PENDING to remain 1, and the new value to appear after the following tick.
- With TICK_DIV=4, BLINK_DIV=3, write CTRL=0x3. Expect `disp_en` to toggle every 12 cycles. Writing CTRL=0x1 returns `disp_en` to steady 1 and STATUS.PHASE to 1.
- Assert `reset_n` low while `mem_ready`=1 during a CTRL write. Expect `mem_ready`=0, CTRL=0 and `disp_en`=0 immediately.
